pe_stream_mux: RTL and testbench



---
 rtl/pe_mux_pkg.sv | 32 +++
 rtl/pe_rr_arb.sv | 20 ++
 rtl/pe_stream_mux.sv | 112 +++++++++++
 tb/tb_pe_stream_mux.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_mux_pkg.sv
// Shared types and helpers for the PE stream selector.
// Holds the FSM state encoding and the round-robin scan function.
package pe_mux_pkg;

    localparam int MAX_SEL = 4;
    localparam int MAX_IN  = 1 << MAX_SEL;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } pe_mux_state_t;

    // First set request at or after ptr, scanning modulo (mask + 1).
    function automatic logic [MAX_SEL-1:0] rr_next(
        input logic [MAX_SEL-1:0] ptr,
        input logic [MAX_IN-1:0]  req,
        input logic [MAX_SEL-1:0] mask
    );
        logic [MAX_SEL-1:0] idx;
        logic               found;
        rr_next = ptr & mask;
        found   = 1'b0;
        for (int i = 0; i < MAX_IN; i++) begin
            idx = (ptr + MAX_SEL'(i)) & mask;
            if (!found && req[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/pe_rr_arb.sv
// Combinational round-robin arbiter for the PE stream selector.
// The rotating pointer is owned by the caller.
module pe_rr_arb
    import pe_mux_pkg::*;
#(
    parameter  int SEL_WIDTH = 2,
    localparam int N_IN      = 1 << SEL_WIDTH
) (
    input  logic [N_IN-1:0]      req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] gnt,
    output logic                 gnt_vld
);

    localparam logic [MAX_SEL-1:0] MASK = MAX_SEL'(N_IN - 1);

    assign gnt     = SEL_WIDTH'(rr_next(MAX_SEL'(ptr), MAX_IN'(req), MASK));
    assign gnt_vld = |req;

endmodule

// File: rtl/pe_stream_mux.sv
// Registered valid/ready N-to-1 stream selector with packet lock.
// Fixed-select or round-robin grant; output beat is registered.
module pe_stream_mux
    import pe_mux_pkg::*;
#(
    parameter  int WIDTH     = 24,
    parameter  int SEL_WIDTH = 2,
    localparam int N_IN      = 1 << SEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_rr,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic [N_IN-1:0]      in_valid,
    output logic [N_IN-1:0]      in_ready,
    input  logic [WIDTH-1:0]     in_data [N_IN-1:0],
    input  logic [N_IN-1:0]      in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SEL_WIDTH-1:0] out_src
);

    pe_mux_state_t        state_q;
    logic [SEL_WIDTH-1:0] lock_idx_q;
    logic [SEL_WIDTH-1:0] ptr_q;
    logic [SEL_WIDTH-1:0] ptr_d;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_data_q;
    logic                 out_last_q;
    logic [SEL_WIDTH-1:0] out_src_q;

    logic [SEL_WIDTH-1:0] rr_gnt;
    logic                 rr_vld;
    logic [SEL_WIDTH-1:0] gnt;
    logic                 gnt_vld;
    logic [SEL_WIDTH-1:0] own_idx;
    logic                 locked;
    logic                 load_en;
    logic                 accept;
    logic                 acc_last;

    pe_rr_arb #(
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_vld (rr_vld)
    );

    always_comb begin
        gnt     = mode_rr ? rr_gnt : sel;
        gnt_vld = mode_rr ? rr_vld : in_valid[sel];
        locked  = (state_q == ST_LOCKED);
        own_idx = locked ? lock_idx_q : gnt;
        load_en = !out_valid_q || out_ready;
        // A locked channel only transfers when it is itself valid.
        accept  = !rst && load_en &&
                  (locked ? in_valid[lock_idx_q] : gnt_vld);
        acc_last = in_last[own_idx];
        ptr_d    = own_idx + SEL_WIDTH'(1);
        in_ready = '0;
        if (!rst && load_en) begin
            in_ready = N_IN'(1) << own_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_idx_q  <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data[own_idx];
                out_last_q  <= acc_last;
                out_src_q   <= own_idx;
                if (acc_last && mode_rr) begin
                    ptr_q <= ptr_d;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && !acc_last) begin
                        state_q    <= ST_LOCKED;
                        lock_idx_q <= gnt;
                    end
                end
                ST_LOCKED: begin
                    if (accept && acc_last) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_pe_stream_mux.sv
// Directed bench for pe_stream_mux: fixed, round-robin, lock,
// backpressure, mode change and mid-packet reset scenarios.
module tb_pe_stream_mux;

    localparam int W  = 24;
    localparam int SW = 2;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode_rr;
    logic [SW-1:0] sel;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  in_data [N-1:0];
    logic [N-1:0]  in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [SW-1:0] out_src;

    int nc = 0;
    int nf = 0;

    always #5 clk = ~clk;

    pe_stream_mux #(
        .WIDTH     (W),
        .SEL_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_rr   (mode_rr),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        mode_rr   = 1'b0;
        sel       = '0;
        in_valid  = 4'b1111;
        in_last   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = 24'h0;
        step();
        step();
        nc++;
        if (out_valid !== 1'b0) begin
            nf++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        nc++;
        if (out_data !== 24'h0 || out_last !== 1'b0 || out_src !== 2'd0) begin
            nf++;
            $display("FAIL reset_fields got %h/%b/%0d want 0/0/0",
                     out_data, out_last, out_src);
        end
        nc++;
        if (in_ready !== 4'b0000) begin
            nf++;
            $display("FAIL reset_ready got %b want 0000", in_ready);
        end
        in_valid = '0;
        rst      = 1'b0;
        step();
    endtask

    task automatic test_fixed();
        logic [W-1:0] d [3];
        d[0] = 24'h000011;
        d[1] = 24'h000022;
        d[2] = 24'h000033;
        mode_rr = 1'b0;
        sel     = 2'd2;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 4'b0100;
            in_data[2] = d[i];
            in_last    = (i == 2) ? 4'b0100 : 4'b0000;
            #1;
            nc++;
            if (in_ready !== 4'b0100) begin
                nf++;
                $display("FAIL fixed_ready beat %0d got %b want 0100", i, in_ready);
            end
            step();
            nc++;
            if (out_valid !== 1'b1 || out_data !== d[i] || out_src !== 2'd2 ||
                out_last !== (i == 2)) begin
                nf++;
                $display("FAIL fixed_beat %0d got v%b %h s%0d l%b want v1 %h s2 l%b",
                         i, out_valid, out_data, out_src, out_last, d[i], (i == 2));
            end
        end
        in_valid = '0;
        in_last  = '0;
        step();
        nc++;
        if (out_valid !== 1'b0 || out_data !== 24'h000033) begin
            nf++;
            $display("FAIL fixed_drain got v%b %h want v0 000033", out_valid, out_data);
        end
    endtask

    task automatic test_rr();
        logic [SW-1:0] e;
        mode_rr  = 1'b1;
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i] = 24'h000100 + W'(i);
        for (int k = 0; k < 5; k++) begin
            e = SW'(k % 4);
            #1;
            nc++;
            if (in_ready !== (4'b0001 << e)) begin
                nf++;
                $display("FAIL rr_ready %0d got %b want %b", k, in_ready, 4'b0001 << e);
            end
            step();
            nc++;
            if (out_valid !== 1'b1 || out_src !== e ||
                out_data !== (24'h000100 + W'(e))) begin
                nf++;
                $display("FAIL rr_beat %0d got v%b s%0d %h want v1 s%0d %h",
                         k, out_valid, out_src, out_data, e, 24'h000100 + W'(e));
            end
        end
        in_valid = '0;
    endtask

    task automatic test_lock_rr();
        mode_rr    = 1'b1;
        in_data[0] = 24'h000300;
        in_data[3] = 24'h000333;
        for (int b = 0; b < 4; b++) begin
            in_valid   = 4'b1011;
            in_data[1] = 24'h000201 + W'(b);
            in_last    = (b == 3) ? 4'b1011 : 4'b1001;
            #1;
            nc++;
            if (in_ready !== 4'b0010) begin
                nf++;
                $display("FAIL lock_ready beat %0d got %b want 0010", b, in_ready);
            end
            step();
            nc++;
            if (out_src !== 2'd1 || out_data !== (24'h000201 + W'(b)) ||
                out_last !== (b == 3)) begin
                nf++;
                $display("FAIL lock_beat %0d got s%0d %h l%b want s1 %h l%b",
                         b, out_src, out_data, out_last, 24'h000201 + W'(b), (b == 3));
            end
        end
        in_valid = 4'b1001;
        in_last  = 4'b1001;
        step();
        nc++;
        if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 24'h000333) begin
            nf++;
            $display("FAIL lock_next3 got v%b s%0d %h want v1 s3 000333",
                     out_valid, out_src, out_data);
        end
        in_valid = 4'b0001;
        step();
        nc++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 24'h000300) begin
            nf++;
            $display("FAIL lock_next0 got v%b s%0d %h want v1 s0 000300",
                     out_valid, out_src, out_data);
        end
        in_valid = '0;
        in_last  = '0;
        step();
    endtask

    task automatic test_backpressure();
        mode_rr    = 1'b0;
        sel        = 2'd0;
        in_valid   = 4'b0001;
        in_last    = 4'b0001;
        in_data[0] = 24'hAAAAAA;
        out_ready  = 1'b1;
        step();
        out_ready  = 1'b0;
        in_data[0] = 24'hBBBBBB;
        for (int c = 0; c < 5; c++) begin
            #1;
            nc++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 ||
                out_data !== 24'hAAAAAA) begin
                nf++;
                $display("FAIL bp_hold %0d got r%b v%b %h want r0000 v1 aaaaaa",
                         c, in_ready, out_valid, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        nc++;
        if (in_ready !== 4'b0001) begin
            nf++;
            $display("FAIL bp_release_ready got %b want 0001", in_ready);
        end
        step();
        nc++;
        if (out_valid !== 1'b1 || out_data !== 24'hBBBBBB) begin
            nf++;
            $display("FAIL bp_release_load got v%b %h want v1 bbbbbb", out_valid, out_data);
        end
        in_valid = '0;
        in_last  = '0;
        step();
    endtask

    task automatic test_mode_change();
        mode_rr    = 1'b0;
        sel        = 2'd0;
        in_data[3] = 24'h000E03;
        for (int b = 0; b < 3; b++) begin
            in_valid   = 4'b1001;
            in_data[0] = 24'h000E00 + W'(b);
            in_last    = (b == 2) ? 4'b1001 : 4'b1000;
            if (b == 1) begin
                mode_rr = 1'b1;
                sel     = 2'd3;
            end
            if (b == 2) mode_rr = 1'b0;
            #1;
            nc++;
            if (in_ready !== 4'b0001) begin
                nf++;
                $display("FAIL mc_ready beat %0d got %b want 0001", b, in_ready);
            end
            step();
            nc++;
            if (out_src !== 2'd0 || out_data !== (24'h000E00 + W'(b))) begin
                nf++;
                $display("FAIL mc_beat %0d got s%0d %h want s0 %h",
                         b, out_src, out_data, 24'h000E00 + W'(b));
            end
        end
        in_valid = 4'b1000;
        step();
        nc++;
        if (out_valid !== 1'b1 || out_src !== 2'd3 || out_data !== 24'h000E03) begin
            nf++;
            $display("FAIL mc_after got v%b s%0d %h want v1 s3 000e03",
                     out_valid, out_src, out_data);
        end
        in_valid = '0;
        in_last  = '0;
        step();
    endtask

    task automatic test_reset_mid();
        mode_rr    = 1'b1;
        in_valid   = 4'b0100;
        in_last    = 4'b0100;
        in_data[2] = 24'h000C20;
        step();
        in_last    = 4'b0000;
        in_data[2] = 24'h000C21;
        step();
        nc++;
        if (out_valid !== 1'b1 || out_src !== 2'd2) begin
            nf++;
            $display("FAIL rm_pre got v%b s%0d want v1 s2", out_valid, out_src);
        end
        #2;
        rst = 1'b1;
        #1;
        nc++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
            nf++;
            $display("FAIL rm_async got v%b r%b want v0 r0000", out_valid, in_ready);
        end
        step();
        rst        = 1'b0;
        in_valid   = 4'b1010;
        in_last    = 4'b1010;
        in_data[1] = 24'h000D01;
        in_data[3] = 24'h000D03;
        step();
        nc++;
        if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 24'h000D01) begin
            nf++;
            $display("FAIL rm_first_gnt got v%b s%0d %h want v1 s1 000d01",
                     out_valid, out_src, out_data);
        end
        in_valid = '0;
        in_last  = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr();
        test_lock_rr();
        test_backpressure();
        test_mode_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end

endmodule
